// File: rtl/param_memory_pkg.sv
// Shared definitions for the parametrised word memory.
//   state_e     : controller states (post-reset clear sweep, normal operation)
//   out_src_e   : which register currently drives the read-data output
//   DefAddrW/DefDataW : default geometry, 4096 x 16 like the original main memory
package param_memory_pkg;

   localparam int unsigned DefAddrW = 12;
   localparam int unsigned DefDataW = 16;

   typedef enum logic {
      S_CLEAR,
      S_READY
   } state_e;

   // Output data source. The RAM read register is never reset, so a separate
   // zero source covers outdata between reset and the first read.
   typedef enum logic [1:0] {
      SrcZero,
      SrcRam,
      SrcBypass
   } out_src_e;

endpackage

// File: rtl/param_memory_if.sv
// Command/response bundle between the CPU control unit and param_memory.
//   addr, read, write, indata, err_clr : master -> memory
//   outdata, outvalid, busy, err       : memory -> master
interface param_memory_if
   import param_memory_pkg::*;
#(
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned DATA_W = DefDataW
) ();

   logic [ADDR_W-1:0] addr;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] indata;
   logic              err_clr;
   logic [DATA_W-1:0] outdata;
   logic              outvalid;
   logic              busy;
   logic              err;

   modport master (
      output addr, read, write, indata, err_clr,
      input  outdata, outvalid, busy, err
   );

   modport slave (
      input  addr, read, write, indata, err_clr,
      output outdata, outvalid, busy, err
   );

endinterface

// File: rtl/param_memory_ram_core.sv
// Bare storage array: one synchronous write port, one synchronous read port.
//   i_clk            : clock
//   i_we/i_waddr/i_wdata : write port, written at posedge when i_we
//   i_re/i_raddr     : read port, read register loads at posedge when i_re
//   o_rdata          : read register; holds its value while i_re is low
// The array and read register carry no reset.
module ram_core
   import param_memory_pkg::*;
#(
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned DATA_W = DefDataW
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int unsigned Depth = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [Depth];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/param_memory.sv
// Parametrised single-port synchronous word memory with optional clear sweep.
//   i_clk   : rising-edge clock
//   i_rst_n : synchronous active-low reset
//   bus     : slave side of param_memory_if
//             addr/read/write/indata : one command per clock
//             err_clr                : clears the sticky error flag
//             outdata/outvalid       : registered read data, 1-cycle valid pulse
//             busy                   : clear sweep running, commands dropped
//             err                    : sticky flag for dropped or colliding commands
module param_memory
   import param_memory_pkg::*;
#(
   parameter int unsigned ADDR_W         = DefAddrW,
   parameter int unsigned DATA_W         = DefDataW,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   param_memory_if.slave  bus
);

   state_e            r_state;
   logic [ADDR_W-1:0] r_cnt;
   out_src_e          r_src;
   logic [DATA_W-1:0] r_bypass;
   logic              r_outvalid;
   logic              r_busy;
   logic              r_err;

   logic              w_clearing;
   logic              w_ready;
   logic              w_we;
   logic              w_re;
   logic [ADDR_W-1:0] w_waddr;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_rdata;
   logic              w_err_set;

   assign w_clearing = (r_state == S_CLEAR);
   assign w_ready    = (r_state == S_READY);

   // Storage ports are gated by reset so an access in a reset cycle is discarded.
   assign w_we    = i_rst_n & (w_clearing | (w_ready & bus.write));
   assign w_waddr = w_clearing ? r_cnt : bus.addr;
   assign w_wdata = w_clearing ? '0 : bus.indata;
   // A colliding read is served from the bypass register, not the array.
   assign w_re    = i_rst_n & w_ready & bus.read & ~bus.write;

   assign w_err_set = (w_clearing & (bus.read | bus.write)) |
                      (w_ready & bus.read & bus.write);

   ram_core #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram_core (
      .i_clk   (i_clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_re    (w_re),
      .i_raddr (bus.addr),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
         r_cnt      <= '0;
         r_src      <= SrcZero;
         r_bypass   <= '0;
         r_outvalid <= 1'b0;
         r_busy     <= CLEAR_ON_RESET;
         r_err      <= 1'b0;
      end else begin
         unique case (r_state)
            S_CLEAR: begin
               r_outvalid <= 1'b0;
               r_cnt      <= r_cnt + 1'b1;
               if (r_cnt == {ADDR_W{1'b1}}) begin
                  r_state <= S_READY;
                  r_busy  <= 1'b0;
               end
            end
            S_READY: begin
               r_outvalid <= bus.read;
               if (bus.read && bus.write) begin
                  r_src    <= SrcBypass;
                  r_bypass <= bus.indata;
               end else if (bus.read) begin
                  r_src <= SrcRam;
               end
            end
         endcase
         // Set wins over a simultaneous clear.
         if (w_err_set) begin
            r_err <= 1'b1;
         end else if (bus.err_clr) begin
            r_err <= 1'b0;
         end
      end
   end

   always_comb begin
      bus.outdata = '0;
      unique case (r_src)
         SrcZero:   bus.outdata = '0;
         SrcRam:    bus.outdata = w_rdata;
         SrcBypass: bus.outdata = r_bypass;
         default:   bus.outdata = '0;
      endcase
   end

   assign bus.outvalid = r_outvalid;
   assign bus.busy     = r_busy;
   assign bus.err      = r_err;

endmodule

// File: tb/tb_param_memory.sv
// Bench for param_memory: instance A (ADDR_W=4, clear sweep on), instance B
// (ADDR_W=12, no sweep). A behavioural model tracks each instance; a compare
// process checks all outputs every cycle, directed steps pin literal values.
module tb_param_memory;

   logic clk;
   logic rst_a;
   logic rst_b;
   int   n_checks;
   int   n_err;

   param_memory_if #(.ADDR_W(4),  .DATA_W(16)) bus_a ();
   param_memory_if #(.ADDR_W(12), .DATA_W(16)) bus_b ();

   param_memory #(.ADDR_W(4), .DATA_W(16), .CLEAR_ON_RESET(1'b1)) dut_a (
      .i_clk   (clk),
      .i_rst_n (rst_a),
      .bus     (bus_a)
   );

   param_memory #(.ADDR_W(12), .DATA_W(16), .CLEAR_ON_RESET(1'b0)) dut_b (
      .i_clk   (clk),
      .i_rst_n (rst_b),
      .bus     (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] mdata [int];  // key = id*65536 + addr; absent = unknown contents
   int          m_busy_left [2];
   logic [15:0] m_out [2];
   bit          m_known [2];
   bit          m_vld [2];
   bit          m_err [2];
   bit          m_init [2];

   task automatic step(input int id, input bit rst_n, input bit rd, input bit wr,
                       input int addr, input logic [15:0] din, input bit eclr,
                       input bit clr_on_rst, input int depth);
      int key;
      key = id * 65536 + addr;
      if (!rst_n) begin
         m_busy_left[id] = clr_on_rst ? depth : 0;
         m_out[id]   = 16'h0;
         m_known[id] = 1'b1;
         m_vld[id]   = 1'b0;
         m_err[id]   = 1'b0;
         m_init[id]  = 1'b1;
      end else if (m_init[id]) begin
         if (m_busy_left[id] > 0) begin
            m_vld[id] = 1'b0;
            if (rd || wr) m_err[id] = 1'b1;
            else if (eclr) m_err[id] = 1'b0;
            m_busy_left[id]--;
            if (m_busy_left[id] == 0) begin
               for (int k = 0; k < depth; k++) mdata[id * 65536 + k] = 16'h0;
            end
         end else begin
            m_vld[id] = rd;
            if (rd && wr) begin
               mdata[key]  = din;
               m_out[id]   = din;
               m_known[id] = 1'b1;
               m_err[id]   = 1'b1;
            end else begin
               if (rd) begin
                  m_known[id] = mdata.exists(key);
                  if (m_known[id]) m_out[id] = mdata[key];
               end else if (wr) begin
                  mdata[key] = din;
               end
               if (eclr) m_err[id] = 1'b0;
            end
         end
      end
   endtask

   always @(posedge clk) begin
      step(0, rst_a, bus_a.read, bus_a.write, int'(bus_a.addr), bus_a.indata,
           bus_a.err_clr, 1'b1, 16);
      step(1, rst_b, bus_b.read, bus_b.write, int'(bus_b.addr), bus_b.indata,
           bus_b.err_clr, 1'b0, 4096);
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (m_init[0]) begin
         chk("a_busy",     32'(bus_a.busy),     32'(m_busy_left[0] > 0));
         chk("a_outvalid", 32'(bus_a.outvalid), 32'(m_vld[0]));
         chk("a_err",      32'(bus_a.err),      32'(m_err[0]));
         if (m_known[0]) chk("a_outdata", 32'(bus_a.outdata), 32'(m_out[0]));
      end
      if (m_init[1]) begin
         chk("b_busy",     32'(bus_b.busy),     32'(m_busy_left[1] > 0));
         chk("b_outvalid", 32'(bus_b.outvalid), 32'(m_vld[1]));
         chk("b_err",      32'(bus_b.err),      32'(m_err[1]));
         if (m_known[1]) chk("b_outdata", 32'(bus_b.outdata), 32'(m_out[1]));
      end
   end

   task automatic idle_all();
      bus_a.read = 1'b0; bus_a.write = 1'b0; bus_a.err_clr = 1'b0;
      bus_b.read = 1'b0; bus_b.write = 1'b0; bus_b.err_clr = 1'b0;
   endtask

   // Counts posedges until busy drops on A; expects the full sweep length.
   task automatic count_sweep(input string name);
      int cnt;
      cnt = 0;
      while (cnt < 100) begin
         @(negedge clk);
         cnt++;
         if (!bus_a.busy) break;
      end
      chk(name, 32'(cnt), 32'd16);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_err    = 0;
      rst_a = 1'b0;
      rst_b = 1'b0;
      bus_a.addr = '0; bus_a.indata = '0;
      bus_b.addr = '0; bus_b.indata = '0;
      idle_all();
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_a_busy",    32'(bus_a.busy),     32'd1);
      chk("rst_a_outdata", 32'(bus_a.outdata),  32'd0);
      chk("rst_a_outvalid",32'(bus_a.outvalid), 32'd0);
      chk("rst_b_busy",    32'(bus_b.busy),     32'd0);
      rst_a = 1'b1;
      rst_b = 1'b1;
      count_sweep("sweep_len");

      // Every word reads back zero after the sweep, back-to-back valid
      for (int i = 0; i <= 16; i++) begin
         if (i > 0) begin
            chk("swept_data",  32'(bus_a.outdata),  32'd0);
            chk("swept_valid", 32'(bus_a.outvalid), 32'd1);
         end
         if (i < 16) begin
            bus_a.addr = 4'(i);
            bus_a.read = 1'b1;
         end else begin
            bus_a.read = 1'b0;
         end
         @(negedge clk);
      end

      // Write then read-after-write on B
      bus_b.addr = 12'h123; bus_b.indata = 16'hBEEF; bus_b.write = 1'b1;
      @(negedge clk);
      bus_b.write = 1'b0; bus_b.read = 1'b1;
      @(negedge clk);
      bus_b.read = 1'b0;
      chk("raw_data",  32'(bus_b.outdata),  32'hBEEF);
      chk("raw_valid", 32'(bus_b.outvalid), 32'd1);
      @(negedge clk);
      chk("idle_valid", 32'(bus_b.outvalid), 32'd0);
      chk("idle_hold",  32'(bus_b.outdata),  32'hBEEF);

      // Collision: write-first bypass and sticky err
      bus_b.addr = 12'h010; bus_b.indata = 16'h5A5A;
      bus_b.read = 1'b1; bus_b.write = 1'b1;
      @(negedge clk);
      bus_b.read = 1'b0; bus_b.write = 1'b0;
      chk("coll_data", 32'(bus_b.outdata), 32'h5A5A);
      chk("coll_err",  32'(bus_b.err),     32'd1);
      bus_b.read = 1'b1;
      @(negedge clk);
      bus_b.read = 1'b0;
      chk("coll_readback", 32'(bus_b.outdata), 32'h5A5A);
      bus_b.err_clr = 1'b1;
      @(negedge clk);
      bus_b.err_clr = 1'b0;
      chk("errclr", 32'(bus_b.err), 32'd0);
      bus_b.err_clr = 1'b1; bus_b.read = 1'b1; bus_b.write = 1'b1; bus_b.indata = 16'h1234;
      @(negedge clk);
      idle_all();
      chk("set_wins", 32'(bus_b.err), 32'd1);
      bus_b.err_clr = 1'b1;
      @(negedge clk);
      bus_b.err_clr = 1'b0;

      // Reset both; write to A during busy; B contents survive reset
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);
      rst_a = 1'b1; rst_b = 1'b1;
      bus_a.addr = 4'h5; bus_a.indata = 16'hFFFF; bus_a.write = 1'b1;
      bus_b.addr = 12'h123; bus_b.read = 1'b1;
      @(negedge clk);
      idle_all();
      chk("busy_write_err", 32'(bus_a.err),      32'd1);
      chk("b_survive",      32'(bus_b.outdata),  32'hBEEF);
      chk("b_no_busy",      32'(bus_b.busy),     32'd0);
      repeat (5) @(negedge clk);
      rst_a = 1'b0;  // reset lands on sweep cycle 7
      @(negedge clk);
      rst_a = 1'b1;
      chk("restart_busy", 32'(bus_a.busy), 32'd1);
      chk("restart_err",  32'(bus_a.err),  32'd0);
      count_sweep("restart_len");
      bus_a.addr = 4'h5; bus_a.read = 1'b1;
      @(negedge clk);
      bus_a.read = 1'b0;
      chk("dropped_write", 32'(bus_a.outdata), 32'd0);

      // Randomized traffic, checked by the per-cycle compare
      for (int n = 0; n < 3000; n++) begin
         rst_a = ($urandom_range(0, 149) != 0);
         rst_b = ($urandom_range(0, 199) != 0);
         bus_a.addr    = 4'($urandom_range(0, 15));
         bus_a.indata  = 16'($urandom);
         bus_a.read    = ($urandom_range(0, 99) < 45);
         bus_a.write   = ($urandom_range(0, 99) < 40);
         bus_a.err_clr = ($urandom_range(0, 99) < 10);
         bus_b.addr    = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095))
                                                     : 12'($urandom_range(0, 31));
         bus_b.indata  = 16'($urandom);
         bus_b.read    = ($urandom_range(0, 99) < 45);
         bus_b.write   = ($urandom_range(0, 99) < 40);
         bus_b.err_clr = ($urandom_range(0, 99) < 10);
         @(negedge clk);
      end

      idle_all();
      rst_a = 1'b1;
      rst_b = 1'b1;
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
